// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder
//
// Iteratively encodes a 32-bit constant as a data-processing immediate
// {rot[3:0], imm8[7:0]}, where the value equals imm8 rotated right by 2*rot.
// One rotation is tried per clock, smallest rotation first. With TRY_INVERT=1
// a failed direct search is followed by a search on ~value (MVN/BIC form).
// The block also reports the shifter carry-out the decoder will produce.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      request, sampled only while busy=0
//   value      constant to encode, captured on the accepting edge
//   cIn        current C flag, captured with value
//   busy       high from the accepting edge until the return to IDLE
//   done       one-cycle result pulse; results hold afterwards
//   found      1 = encodable
//   imm8       encoded immediate
//   rot        rotate field (rotation = 2*rot, right)
//   operand12  {rot, imm8}
//   inverted   1 = encoding represents ~value
//   shiftCout  decoder carry-out for this encoding
module imm_rot_encoder #(
  parameter bit TRY_INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        cIn,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [7:0]  imm8,
  output logic [3:0]  rot,
  output logic [11:0] operand12,
  output logic        inverted,
  output logic        shiftCout
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] v;
  logic        c;
  logic [3:0]  k;
  logic        pass;

  logic [31:0] cand;
  logic [5:0]  shAmt;
  logic [31:0] rotated;
  logic        hit;

  // Rotating the candidate left by 2*k brings the would-be imm8 into the low
  // byte; the trial hits when every other bit is zero. A shift by 32 (k=0)
  // yields zero, so the OR still gives the unrotated candidate.
  always_comb begin
    cand    = pass ? ~v : v;
    shAmt   = {1'b0, k, 1'b0};
    rotated = (cand << shAmt) | (cand >> (6'd32 - shAmt));
    hit     = (rotated[31:8] == 24'd0);
  end

  assign operand12 = {rot, imm8};

  // Single control/datapath register block. Results are only written on the
  // cycle that raises done, so they hold until the next completion or reset.
  // The decoded operand of a hit is exactly the candidate, so its bit 31 is
  // the carry-out whenever the rotation is nonzero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      imm8      <= 8'd0;
      rot       <= 4'd0;
      inverted  <= 1'b0;
      shiftCout <= 1'b0;
      v         <= 32'd0;
      c         <= 1'b0;
      k         <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            v     <= value;
            c     <= cIn;
            k     <= 4'd0;
            pass  <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            imm8      <= rotated[7:0];
            rot       <= k;
            found     <= 1'b1;
            inverted  <= pass;
            shiftCout <= (k == 4'd0) ? c : cand[31];
            done      <= 1'b1;
            state     <= DONE;
          end else if (k != 4'd15) begin
            k <= k + 4'd1;
          end else if (TRY_INVERT && !pass) begin
            pass <= 1'b1;
            k    <= 4'd0;
          end else begin
            imm8      <= 8'd0;
            rot       <= 4'd0;
            found     <= 1'b0;
            inverted  <= 1'b0;
            shiftCout <= c;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboard bench for imm_rot_encoder. Two instances share the inputs:
// dut 0 with TRY_INVERT=0 and dut 1 with TRY_INVERT=1. Each request pushes a
// model-computed expectation (fields plus done latency) into a per-instance
// queue; a negedge monitor pops and compares whenever done is seen.
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        cIn;

  logic        busyS      [2];
  logic        doneS      [2];
  logic        foundS     [2];
  logic [7:0]  imm8S      [2];
  logic [3:0]  rotS       [2];
  logic [11:0] operand12S [2];
  logic        invertedS  [2];
  logic        shiftCoutS [2];

  typedef struct {
    logic       found;
    logic [7:0] imm;
    logic [3:0] rot;
    logic       inv;
    logic       cout;
    int         lat;
    int         acceptCyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nCompare = 0;
  int nFail    = 0;
  int cyc      = 0;
  logic prevDone [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  imm_rot_encoder #(.TRY_INVERT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .value(value), .cIn(cIn),
    .busy(busyS[0]), .done(doneS[0]), .found(foundS[0]), .imm8(imm8S[0]),
    .rot(rotS[0]), .operand12(operand12S[0]), .inverted(invertedS[0]),
    .shiftCout(shiftCoutS[0])
  );

  imm_rot_encoder #(.TRY_INVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .value(value), .cIn(cIn),
    .busy(busyS[1]), .done(doneS[1]), .found(foundS[1]), .imm8(imm8S[1]),
    .rot(rotS[1]), .operand12(operand12S[1]), .inverted(invertedS[1]),
    .shiftCout(shiftCoutS[1])
  );

  // Reference model: search rotations by bit-index arithmetic. For each k the
  // immediate is read out of the candidate, decoded back by rotating right and
  // accepted when the decode reproduces the candidate exactly.
  function automatic exp_t model(input logic [31:0] val, input logic cin, input bit tryInv);
    exp_t e;
    logic [31:0] t;
    logic [7:0]  im;
    logic [31:0] dec;
    int          src;
    e.found = 1'b0; e.imm = 8'd0; e.rot = 4'd0; e.inv = 1'b0; e.cout = cin;
    e.lat = tryInv ? 32 : 16;
    e.acceptCyc = 0;
    for (int p = 0; p < (tryInv ? 2 : 1); p++) begin
      t = (p == 1) ? ~val : val;
      for (int kk = 0; kk < 16; kk++) begin
        if (!e.found) begin
          for (int j = 0; j < 8; j++) im[j] = t[(j + 32 - 2 * kk) % 32];
          for (int i = 0; i < 32; i++) begin
            src = (i + 2 * kk) % 32;
            dec[i] = (src < 8) ? im[src] : 1'b0;
          end
          if (dec == t) begin
            e.found = 1'b1;
            e.imm   = im;
            e.rot   = 4'(kk);
            e.inv   = (p == 1);
            e.cout  = (kk == 0) ? cin : t[31];
            e.lat   = 16 * p + kk + 1;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic cmp(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompare++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL dut%0d %s: got %h expected %h (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  // Monitor body: every done pulse must match the oldest outstanding request.
  task automatic checkOutput(input int d);
    exp_t e;
    if (prevDone[d]) begin
      cmp(d, "busy_after_done", 32'(busyS[d]), 32'd0);
      cmp(d, "done_width", 32'(doneS[d]), 32'd0);
    end
    if (doneS[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        cmp(d, "unexpected_done", 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp(d, "latency", 32'(cyc - e.acceptCyc), 32'(e.lat));
        cmp(d, "busy", 32'(busyS[d]), 32'd1);
        cmp(d, "found", 32'(foundS[d]), 32'(e.found));
        cmp(d, "imm8", 32'(imm8S[d]), 32'(e.imm));
        cmp(d, "rot", 32'(rotS[d]), 32'(e.rot));
        cmp(d, "operand12", 32'(operand12S[d]), 32'({e.rot, e.imm}));
        cmp(d, "inverted", 32'(invertedS[d]), 32'(e.inv));
        cmp(d, "shiftCout", 32'(shiftCoutS[d]), 32'(e.cout));
      end
    end
    prevDone[d] = doneS[d];
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput(0);
      checkOutput(1);
    end
  end

  task automatic checkZero(input string name);
    for (int d = 0; d < 2; d++)
      cmp(d, name, {3'd0, busyS[d], doneS[d], foundS[d], imm8S[d], rotS[d],
                    operand12S[d], invertedS[d], shiftCoutS[d]}, 32'd0);
  endtask

  // Issues a one-cycle start pulse; both instances must be idle.
  task automatic applyStimulus(input logic [31:0] val, input logic cin);
    exp_t e;
    @(negedge clk);
    value = val;
    cIn   = cin;
    start = 1'b1;
    e = model(val, cin, 1'b0); e.acceptCyc = cyc + 1; q0.push_back(e);
    e = model(val, cin, 1'b1); e.acceptCyc = cyc + 1; q1.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    nCompare++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nFail++;
      $display("[TB] FAIL timeout: outstanding %0d/%0d expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  // Start held high: accepts every lat+2 cycles, one done per accept.
  task automatic heldStart(input logic cin, input int nEdges);
    exp_t e;
    int per;
    int c0;
    @(negedge clk);
    value = 32'h1;
    cIn   = cin;
    start = 1'b1;
    c0 = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      e = model(32'h1, cin, d == 1);
      per = e.lat + 2;
      for (int m = 0; m * per <= nEdges - 1; m++) begin
        e.acceptCyc = c0 + m * per;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    repeat (nEdges) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] imm32;
    logic [63:0] dbl;
    int kk;
    reset = 1'b1;
    start = 1'b0;
    value = 32'h0;
    cIn   = 1'b0;
    repeat (3) @(negedge clk);
    checkZero("reset_state");
    reset = 1'b0;

    applyStimulus(32'h000000FF, 1'b1); waitIdle();
    applyStimulus(32'hFF000000, 1'b0); waitIdle();
    applyStimulus(32'h00000104, 1'b1); waitIdle();
    applyStimulus(32'h00000102, 1'b1); waitIdle();
    applyStimulus(32'h00000102, 1'b0); waitIdle();
    applyStimulus(32'hFFFFFF00, 1'b0); waitIdle();
    applyStimulus(32'h00000000, 1'b1); waitIdle();
    applyStimulus(32'hFFFFFFFF, 1'b1); waitIdle();
    applyStimulus(32'h80000001, 1'b0); waitIdle();

    // Reset mid-search: request dropped, outputs cleared, next request normal.
    applyStimulus(32'h00000104, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q0.delete();
    q1.delete();
    checkZero("reset_abort");
    reset = 1'b0;
    value = 32'h000000FF;
    cIn   = 1'b1;
    start = 1'b1;
    begin
      exp_t e;
      e = model(32'h000000FF, 1'b1, 1'b0); e.acceptCyc = cyc + 1; q0.push_back(e);
      e = model(32'h000000FF, 1'b1, 1'b1); e.acceptCyc = cyc + 1; q1.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    heldStart(1'b1, 10);
    waitIdle();

    for (int i = 0; i < 60; i++) begin
      kk = $urandom_range(0, 15);
      imm32 = 32'($urandom_range(0, 255));
      dbl = {imm32, imm32} >> (2 * kk);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = dbl[31:0];
        2: v = ~dbl[31:0];
        default: v = 32'($urandom_range(0, 4095));
      endcase
      applyStimulus(v, 1'($urandom_range(0, 1)));
      waitIdle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
    $finish;
  end

endmodule

// File: doc/imm_rot_encoder.md
# imm_rot_encoder

Iterative encoder that converts a 32-bit constant into the data-processing immediate operand field {rotate[3:0], imm8[7:0]}. The value is recovered by rotating imm8 right by 2*rotate. This is the inverse of the shifter/sign-extender immediate path. The block sits beside the instruction-build/test-stimulus logic: it tests one rotation per clock, reports the smallest legal rotation, and also reports the shifter carry-out the decoder will produce for that encoding.

## Interface
Parameters:
- TRY_INVERT, default 0: when 1, a failed direct search is followed by a second search on ~value (MVN/BIC form).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- value  input  32  constant to encode; captured on the accepting edge
- cIn  input  1  current C flag; captured with value
- busy  output  1  high from the accepting edge until the edge that returns to IDLE
- done  output  1  one-cycle pulse; result outputs valid while high and held afterwards
- found  output  1  1 = encodable
- imm8  output  8  encoded immediate
- rot  output  4  rotate field (actual rotation = 2*rot, right)
- operand12  output  12  {rot, imm8}
- inverted  output  1  1 = the encoding represents ~value
- shiftCout  output  1  carry-out the decoder produces for this encoding

## Operation
- States: IDLE, SEARCH, DONE. Pass flag `pass` (0 = direct, 1 = inverted). Counter `k` is 4 bits.
- IDLE:
  - If start=1, latch v=value and c=cIn, set k=0 and pass=0, then go to SEARCH.
  - If start=0, stay in IDLE.
- SEARCH:
  - Candidate t = pass ? ~v : v.
  - Test r = t rotated left by 2*k (32-bit wrap rotate).
  - Hit when r[31:8] == 0. On a hit: imm8=r[7:0], rot=k, found=1, inverted=pass, then go to DONE.
  - Miss with k<15: k=k+1, stay in SEARCH.
  - Miss with k==15 and (TRY_INVERT=0 or pass=1): found=0, imm8=0, rot=0, inverted=0, then go to DONE.
  - Miss with k==15, TRY_INVERT=1 and pass=0: pass=1, k=0, stay in SEARCH.
- The smallest k wins. Direct encoding always takes precedence over inverted.
- shiftCout:
  - rot==0: c.
  - rot!=0: t[31], i.e. bit 31 of the decoded operand.
  - found=0: c.
- DONE: done=1 for this cycle only. Next state is IDLE unconditionally. start in DONE is ignored.
- start while busy=1 is ignored; there is no queueing.
- value=0 encodes as imm8=0x00, rot=0, found=1.
- Reset values: state IDLE, busy=0, done=0, found=0, imm8=0, rot=0, operand12=0, inverted=0, shiftCout=0, k=0, pass=0.
- Reset mid-search aborts with no done pulse. Result registers clear.

## Timing
- Accepting edge E0 (start=1, busy=0): busy becomes 1 after E0. Trial k of pass p is evaluated in the cycle after edge E(16p+k).
- Hit at trial (p,k): results registered and done=1 after edge E(16p+k+1).
- Return to IDLE and busy=0 after edge E(16p+k+2).
- Direct-pass miss (TRY_INVERT=0): done after E16.
- Worst case (TRY_INVERT=1, both passes miss): done after E32.
- Back-to-back requests: a new start is accepted at the first edge with busy=0, so the minimum period is 3 cycles.
- Results hold until the next done pulse or reset.
- reset takes priority over start on the same edge.

## Test plan
- value=0x000000FF, cIn=1, start pulse -> done after E1; found=1, imm8=0xFF, rot=0, operand12=0x0FF, shiftCout=1, inverted=0; busy low after E2.
- value=0xFF000000, cIn=0 -> done after E5; imm8=0xFF, rot=4, operand12=0x4FF, shiftCout=1.
- value=0x00000104 -> done after E16; imm8=0x41, rot=15, operand12=0xF41, shiftCout=0 (bit 31 of 0x104); and value=0x00000102 -> done after E16, found=0, operand12=0x000, shiftCout=cIn.
- TRY_INVERT=1, value=0xFFFFFF00, cIn=0 -> done after E17; found=1, inverted=1, imm8=0xFF, rot=0, shiftCout=0.
- value=0x00000104 started, reset asserted at E5 -> no done pulse ever; all outputs 0 after E5; start at E6 with value=0x000000FF completes normally with done after E7.
- start held high continuously with value=0x00000001 -> requests accepted at E0, E3, E6, …; exactly one done per request; start during busy/DONE has no effect.
